dm_arbiter: RTL and testbench

- Arbitrates the single data-memory port (2048 x 32-bit words, 11-bit word address, per-byte write lanes) between two requesters.
  - Port 0 is the CPU MEM stage.
  - Port 1 is the DMA/bridge master.
- Converts size plus address into lane enables and lane-replicated write data.
- Registers read data and returns it one cycle after grant.
- Sits between the pipeline MEM stage / bridge and the DM array; stalls the pipeline via the absence of gnt0.

---
 rtl/dm_arb_pkg.sv | 23 ++
 rtl/dm_arb_lane_gen.sv | 51 +++++
 rtl/dm_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_dm_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dm_arb_pkg.sv
// -----------------------------------------------------------------------------
// dm_arb_pkg
// Shared definitions for the data-memory arbiter:
//   - access size codes (byte / half / word; code 2'b11 is treated as word)
//   - owner state encodings for the arbiter state register
//   - data-memory depth in 32-bit words
// -----------------------------------------------------------------------------
package dm_arb_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  localparam int DM_DEPTH = 2048;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN0  = 2'd1,
    OWN1  = 2'd2,
    LOCK1 = 2'd3
  } own_t;

endpackage

// File: rtl/dm_arb_lane_gen.sv
// -----------------------------------------------------------------------------
// dm_lane_gen
// Combinational byte-lane generator for one memory access.
//   size     in  2   access size code (SIZE_B / SIZE_H / SIZE_W, 11 = word)
//   off      in  2   byte offset within the word (addr[1:0])
//   din      in  32  right-aligned store data
//   be       out 4   byte-lane enables
//   dout     out 32  lane-replicated store data
//   misalign out 1   half on an odd byte, or word not on a word boundary
// Misaligned offsets are truncated here (half uses off[1], word ignores off);
// the caller decides whether to suppress the access.
// -----------------------------------------------------------------------------
module dm_lane_gen
  import dm_arb_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  off,
  input  logic [31:0] din,
  output logic [3:0]  be,
  output logic [31:0] dout,
  output logic        misalign
);

  always_comb begin
    be   = 4'b1111;
    dout = din;
    case (size)
      SIZE_B: begin
        be   = 4'b0001 << off;
        dout = {4{din[7:0]}};
      end
      SIZE_H: begin
        be   = off[1] ? 4'b1100 : 4'b0011;
        dout = {2{din[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        dout = din;
      end
    endcase
  end

  always_comb begin
    misalign = 1'b0;
    if (size == SIZE_H)
      misalign = off[0];
    else if (size == SIZE_W || size == 2'b11)
      misalign = (off != 2'b00);
  end

endmodule

// File: rtl/dm_arbiter.sv
// -----------------------------------------------------------------------------
// dm_arbiter
// Two-port arbiter in front of the single data-memory port.
// Port 0 is the CPU MEM stage, port 1 the DMA/bridge master.
//
// Parameters
//   AW        DM word-address width (word index = addr[AW+1:2])
//   MAX_WAIT  cycles port 1 may be denied before it gets forced priority
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   reqN/weN/sizeN      request, store(1)/load(0), size code
//   addrN/wdataN        byte address, right-aligned store data
//   lock1               port 1 burst lock (keeps ownership while req1 high)
//   gntN                combinational grant; the access happens this cycle
//   rvalidN, rdata      registered load return, one cycle after grant
//   mem_addr/mem_we     DM word address and write strobe
//   mem_be/mem_wdata    DM byte-lane enables and lane-replicated data
//   mem_rdata           DM combinational read word
//
// Optional build macro DM_ARB_ALIGN_CHECK_EN adds err0/err1: misaligned
// half/word accesses are granted but write nothing, return zero read data
// and pulse errN one cycle later.
// -----------------------------------------------------------------------------
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW       = $clog2(DM_DEPTH),
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          we0,
  input  logic [1:0]    size0,
  input  logic [31:0]   addr0,
  input  logic [31:0]   wdata0,
  input  logic          req1,
  input  logic          we1,
  input  logic [1:0]    size1,
  input  logic [31:0]   addr1,
  input  logic [31:0]   wdata1,
  input  logic          lock1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [31:0]   rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [3:0]    mem_be,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
`ifdef DM_ARB_ALIGN_CHECK_EN
  ,
  output logic          err0,
  output logic          err1
`endif
);

  localparam logic [3:0] WAIT_LIM = 4'(MAX_WAIT);

  own_t       own_q, own_d;
  logic [3:0] wait_q, wait_d;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      own_q  <= IDLE;
      wait_q <= 4'd0;
    end else begin
      own_q  <= own_d;
      wait_q <= wait_d;
    end
  end

  // Next state and starvation counter
  always_comb begin
    own_d = IDLE;
    if (gnt1)
      own_d = lock1 ? LOCK1 : OWN1;
    else if (gnt0)
      own_d = OWN0;

    wait_d = wait_q;
    if (!req1 || gnt1)
      wait_d = 4'd0;
    else if (wait_q != 4'hF)
      wait_d = wait_q + 4'd1;
  end

  // Grant (first match wins); a lock only counts while req1 is still high,
  // so a dropped req1 is arbitrated normally in the same cycle.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (own_q == LOCK1 && req1)
        gnt1 = 1'b1;
      else if (req1 && wait_q >= WAIT_LIM)
        gnt1 = 1'b1;
      else if (req0)
        gnt0 = 1'b1;
      else if (req1)
        gnt1 = 1'b1;
    end
  end

  // Request mux: with no grant, port 0's fields are presented (don't-care)
  logic        we_m;
  logic [1:0]  size_m;
  logic [31:0] addr_m;
  logic [31:0] wdata_m;
  logic [3:0]  be_m;
  logic        misalign_m;
  logic        bad_m;

  assign we_m    = gnt1 ? we1    : we0;
  assign size_m  = gnt1 ? size1  : size0;
  assign addr_m  = gnt1 ? addr1  : addr0;
  assign wdata_m = gnt1 ? wdata1 : wdata0;

  dm_lane_gen u_lane_gen (
    .size     (size_m),
    .off      (addr_m[1:0]),
    .din      (wdata_m),
    .be       (be_m),
    .dout     (mem_wdata),
    .misalign (misalign_m)
  );

`ifdef DM_ARB_ALIGN_CHECK_EN
  assign bad_m = misalign_m;
  logic unused_bits;
  assign unused_bits = ^addr_m[31:AW+2];
`else
  assign bad_m = 1'b0;
  logic unused_bits;
  assign unused_bits = ^{addr_m[31:AW+2], misalign_m};
`endif

  assign mem_addr = addr_m[AW+1:2];
  assign mem_we   = (gnt0 | gnt1) & we_m & ~bad_m;
  assign mem_be   = bad_m ? 4'b0000 : be_m;

  logic ld0_p0, ld1_p0;
  assign ld0_p0 = gnt0 & ~we0;
  assign ld1_p0 = gnt1 & ~we1;

  // p0 -> p1: load return register
  logic        vld0_p1, vld1_p1;
  logic [31:0] rdata_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      vld0_p1  <= 1'b0;
      vld1_p1  <= 1'b0;
      rdata_p1 <= 32'h0;
    end else begin
      vld0_p1 <= ld0_p0;
      vld1_p1 <= ld1_p0;
      if (ld0_p0 || ld1_p0)
        rdata_p1 <= bad_m ? 32'h0 : mem_rdata;
    end
  end

  assign rvalid0 = vld0_p1;
  assign rvalid1 = vld1_p1;
  assign rdata   = rdata_p1;

`ifdef DM_ARB_ALIGN_CHECK_EN
  // p0 -> p1: alignment error flags
  logic err0_p1, err1_p1;

  always_ff @(posedge clk) begin
    if (reset) begin
      err0_p1 <= 1'b0;
      err1_p1 <= 1'b0;
    end else begin
      err0_p1 <= gnt0 & bad_m;
      err1_p1 <= gnt1 & bad_m;
    end
  end

  assign err0 = err0_p1;
  assign err1 = err1_p1;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
`timescale 1ns/1ps
module tb_dm_arbiter;

  localparam int AW       = 11;
  localparam int MAX_WAIT = 4;
  localparam logic [1:0] SB = 2'b00, SH = 2'b01, SW = 2'b10;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, we0, req1, we1, lock1;
  logic [1:0]    size0, size1;
  logic [31:0]   addr0, wdata0, addr1, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0]   rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [31:0]   mem_wdata, mem_rdata;
`ifdef DM_ARB_ALIGN_CHECK_EN
  logic          err0, err1;
`endif

  dm_arbiter #(.AW(AW), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .we0(we0), .size0(size0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .we1(we1), .size1(size1), .addr1(addr1), .wdata1(wdata1),
    .lock1(lock1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DM_ARB_ALIGN_CHECK_EN
    , .err0(err0), .err1(err1)
`endif
  );

  always #5 clk = ~clk;

  // Data memory attached to the DUT
  logic [31:0] dm [0:2047];
  assign mem_rdata = dm[mem_addr];
  always @(posedge clk)
    if (mem_we)
      for (int i = 0; i < 4; i++)
        if (mem_be[i]) dm[mem_addr][8*i +: 8] <= mem_wdata[8*i +: 8];

  // Reference model: byte-addressed memory plus arbitration bookkeeping
  logic [7:0]  rmem [0:8191];
  bit          m_locked, m_rv0, m_rv1, m_err0, m_err1;
  int          m_wait;
  logic [31:0] m_rd;
  bit          e_g0, e_g1, e_we;
  int          checks = 0;
  int          errors = 0;

  function automatic bit misal(input logic [1:0] sz, input logic [31:0] a);
    bit r;
    r = 1'b0;
`ifdef DM_ARB_ALIGN_CHECK_EN
    if (sz == SH) r = a[0];
    else if (sz != SB) r = (a[1:0] != 2'b00);
`else
    r = (sz == 2'b11) && (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    return r;
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    int b;
    b = int'(a[12:2]) * 4;
    return {rmem[b+3], rmem[b+2], rmem[b+1], rmem[b]};
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d);
    int b;
    b = int'(a[12:0]);
    if (sz == SB) rmem[b] = d[7:0];
    else if (sz == SH) begin
      b = b & ~1;
      rmem[b] = d[7:0]; rmem[b+1] = d[15:8];
    end else begin
      b = b & ~3;
      for (int i = 0; i < 4; i++) rmem[b+i] = d[8*i +: 8];
    end
  endtask

  // Port 1 wins when it is locked in or has waited long enough, or port 0 is idle
  task automatic predict();
    bit prio1;
    prio1 = m_locked || (m_wait >= MAX_WAIT);
    e_g1  = !reset && req1 && (prio1 || !req0);
    e_g0  = !reset && req0 && !e_g1;
    e_we  = e_g0 ? (we0 && !misal(size0, addr0)) :
            e_g1 ? (we1 && !misal(size1, addr1)) : 1'b0;
  endtask

  task automatic sample();
    #4;
    predict();
  endtask

  task automatic advance();
    bit w;
    logic [1:0] sz;
    logic [31:0] a, d;
    @(posedge clk);
    if (reset) begin
      m_locked = 0; m_wait = 0; m_rv0 = 0; m_rv1 = 0; m_rd = 32'h0; m_err0 = 0; m_err1 = 0;
    end else begin
      w  = e_g1 ? we1 : we0;
      sz = e_g1 ? size1 : size0;
      a  = e_g1 ? addr1 : addr0;
      d  = e_g1 ? wdata1 : wdata0;
      m_rv0  = e_g0 && !we0;
      m_rv1  = e_g1 && !we1;
      m_err0 = e_g0 && misal(size0, addr0);
      m_err1 = e_g1 && misal(size1, addr1);
      if (e_g0 || e_g1) begin
        if (!w) m_rd = misal(sz, a) ? 32'h0 : ref_word(a);
        else if (!misal(sz, a)) ref_store(sz, a, d);
      end
      m_locked = e_g1 && lock1;
      m_wait   = (!req1 || e_g1) ? 0 : ((m_wait < 15) ? m_wait + 1 : 15);
    end
    #1;
  endtask

  task automatic set0(input bit r, input bit w, input logic [1:0] s,
                      input logic [31:0] a, input logic [31:0] d);
    req0 = r; we0 = w; size0 = s; addr0 = a; wdata0 = d;
  endtask

  task automatic set1(input bit r, input bit w, input logic [1:0] s,
                      input logic [31:0] a, input logic [31:0] d, input bit l);
    req1 = r; we1 = w; size1 = s; addr1 = a; wdata1 = d; lock1 = l;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set0(1, 1, SW, 32'h40, 32'h1111_1111);
    set1(1, 1, SW, 32'h44, 32'h2222_2222, 1);
    sample();
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b want 00", gnt0, gnt1); end
    checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", mem_we); end
    advance();
    sample();
    checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b want 00", rvalid0, rvalid1); end
    checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    advance();
    reset = 1'b0;
    set0(0, 0, SW, 0, 0);
    set1(0, 0, SW, 0, 0, 0);
  endtask

  task automatic test_store_load();
    set0(1, 1, SW, 32'h10, 32'hDEAD_BEEF);
    sample();
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL sw_gnt: got %b%b want 10", gnt0, gnt1); end
    checks++; if (mem_we !== 1'b1 || mem_be !== 4'b1111 || mem_addr !== 11'd4) begin errors++; $display("FAIL sw_mem: got we=%b be=%b a=%0d want 1 1111 4", mem_we, mem_be, mem_addr); end
    checks++; if (mem_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL sw_wdata: got %h want deadbeef", mem_wdata); end
    advance();
    set0(1, 0, SW, 32'h10, 32'h0);
    sample();
    checks++; if (gnt0 !== 1'b1 || mem_we !== 1'b0) begin errors++; $display("FAIL lw_gnt: got gnt0=%b we=%b want 1 0", gnt0, mem_we); end
    advance();
    set0(0, 0, SW, 32'h0, 32'h0);
    sample();
    checks++; if (rvalid0 !== 1'b1 || rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rdata: got v=%b %h want 1 deadbeef", rvalid0, rdata); end
    advance();
    sample();
    checks++; if (rvalid0 !== 1'b0) begin errors++; $display("FAIL lw_pulse: got %b want 0", rvalid0); end
    advance();
    set0(1, 1, SB, 32'h13, 32'h0000_00A5);
    sample();
    checks++; if (mem_be !== 4'b1000 || mem_wdata !== 32'hA5A5_A5A5) begin errors++; $display("FAIL sb_lanes: got %b %h want 1000 a5a5a5a5", mem_be, mem_wdata); end
    advance();
    set0(1, 1, SH, 32'h16, 32'h0000_1234);
    sample();
    checks++; if (mem_be !== 4'b1100 || mem_wdata !== 32'h1234_1234) begin errors++; $display("FAIL sh_lanes: got %b %h want 1100 12341234", mem_be, mem_wdata); end
    advance();
    set0(1, 0, SW, 32'h10, 32'h0);
    sample();
    advance();
    set0(1, 0, SW, 32'h14, 32'h0);
    sample();
    checks++; if (rvalid0 !== 1'b1 || rdata !== 32'hA5AD_BEEF) begin errors++; $display("FAIL b2b_first: got v=%b %h want 1 a5adbeef", rvalid0, rdata); end
    advance();
    set0(0, 0, SW, 32'h0, 32'h0);
    sample();
    checks++; if (rvalid0 !== 1'b1 || rdata !== 32'h1234_0000) begin errors++; $display("FAIL b2b_second: got v=%b %h want 1 12340000", rvalid0, rdata); end
    advance();
  endtask

  task automatic test_fairness();
    bit want1;
    set0(1, 1, SW, 32'h100, 32'h0);
    set1(1, 1, SW, 32'h104, 32'h0, 0);
    for (int k = 0; k < 15; k++) begin
      wdata0 = 32'(k);
      want1 = ((k % 5) == 4);
      sample();
      checks++; if (gnt1 !== want1 || gnt0 !== !want1) begin errors++; $display("FAIL fair_%0d: got %b%b want %b%b", k, gnt0, gnt1, !want1, want1); end
      advance();
    end
    set0(0, 0, SW, 0, 0);
    set1(0, 0, SW, 0, 0, 0);
    sample();
    advance();
  endtask

  task automatic test_lock();
    set1(1, 1, SW, 32'h200, 32'h5555_0000, 1);
    sample();
    checks++; if (gnt1 !== 1'b1) begin errors++; $display("FAIL lock_acq: got %b want 1", gnt1); end
    advance();
    set0(1, 1, SW, 32'h300, 32'h7777_7777);
    for (int k = 0; k < 6; k++) begin
      wdata1 = 32'h5555_0001 + 32'(k);
      sample();
      checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL lock_%0d: got %b%b want 01", k, gnt0, gnt1); end
      advance();
    end
    set1(0, 0, SW, 0, 0, 0);
    sample();
    checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL lock_rel: got %b%b want 10", gnt0, gnt1); end
    advance();
    set0(0, 0, SW, 0, 0);
    sample();
    advance();
  endtask

  task automatic test_reset_burst();
    set1(1, 0, SW, 32'h10, 32'h0, 1);
    sample();
    advance();
    set0(1, 0, SW, 32'h14, 32'h0);
    sample();
    checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin errors++; $display("FAIL rb_locked: got %b%b want 01", gnt0, gnt1); end
    advance();
    reset = 1'b1;
    sample();
    checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || rvalid1 !== 1'b1) begin errors++; $display("FAIL rb_inreset: got g=%b%b v1=%b want 00 1", gnt0, gnt1, rvalid1); end
    advance();
    reset = 1'b0;
    sample();
    checks++; if (rvalid1 !== 1'b0 || gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL rb_after: got v1=%b g=%b%b want 0 10", rvalid1, gnt0, gnt1); end
    advance();
    set0(0, 0, SW, 0, 0);
    set1(0, 0, SW, 0, 0, 0);
    sample();
    checks++; if (rvalid0 !== 1'b1 || rdata !== 32'h1234_0000) begin errors++; $display("FAIL rb_load0: got v=%b %h want 1 12340000", rvalid0, rdata); end
    advance();
  endtask

`ifdef DM_ARB_ALIGN_CHECK_EN
  task automatic test_align();
    set0(1, 1, SW, 32'h02, 32'hCAFE_F00D);
    sample();
    checks++; if (gnt0 !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b0000) begin errors++; $display("FAIL al_store: got g=%b we=%b be=%b want 1 0 0000", gnt0, mem_we, mem_be); end
    advance();
    set0(1, 0, SW, 32'h00, 32'h0);
    sample();
    checks++; if (err0 !== 1'b1) begin errors++; $display("FAIL al_err: got %b want 1", err0); end
    advance();
    set0(0, 0, SW, 0, 0);
    sample();
    checks++; if (err0 !== 1'b0 || rvalid0 !== 1'b1 || rdata !== 32'h0) begin errors++; $display("FAIL al_read: got e=%b v=%b %h want 0 1 0", err0, rvalid0, rdata); end
    advance();
  endtask
`endif

  task automatic test_random();
    bit a0, a1;
    a0 = 0; a1 = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!a0 && $urandom_range(0, 2) != 0) begin
        a0 = 1;
        set0(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             ($urandom() & 32'hFFFF_E000) | 32'($urandom_range(0, 127)), $urandom());
      end
      if (!a1 && $urandom_range(0, 1) == 0) begin
        a1 = 1;
        set1(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
             ($urandom() & 32'hFFFF_E000) | 32'($urandom_range(0, 127)), $urandom(),
             ($urandom_range(0, 3) == 0));
      end
      req0 = a0;
      req1 = a1;
      if (!a1) lock1 = 1'b0;
      reset = ($urandom_range(0, 199) == 0);
      sample();
      checks++; if (gnt0 !== e_g0 || gnt1 !== e_g1) begin errors++; $display("FAIL rnd_gnt @%0d: got %b%b want %b%b", n, gnt0, gnt1, e_g0, e_g1); end
      checks++; if (mem_we !== e_we) begin errors++; $display("FAIL rnd_we @%0d: got %b want %b", n, mem_we, e_we); end
      checks++; if (rvalid0 !== m_rv0 || rvalid1 !== m_rv1) begin errors++; $display("FAIL rnd_rvalid @%0d: got %b%b want %b%b", n, rvalid0, rvalid1, m_rv0, m_rv1); end
      if (m_rv0 || m_rv1) begin
        checks++; if (rdata !== m_rd) begin errors++; $display("FAIL rnd_rdata @%0d: got %h want %h", n, rdata, m_rd); end
      end
      if (e_g0 || e_g1) begin
        checks++; if (mem_addr !== (e_g1 ? addr1[12:2] : addr0[12:2])) begin errors++; $display("FAIL rnd_addr @%0d: got %0d want %0d", n, mem_addr, e_g1 ? addr1[12:2] : addr0[12:2]); end
      end
`ifdef DM_ARB_ALIGN_CHECK_EN
      checks++; if (err0 !== m_err0 || err1 !== m_err1) begin errors++; $display("FAIL rnd_err @%0d: got %b%b want %b%b", n, err0, err1, m_err0, m_err1); end
`endif
      advance();
      if (e_g0) a0 = 0;
      if (e_g1) a1 = 0;
    end
    reset = 1'b0;
    set0(0, 0, SW, 0, 0);
    set1(0, 0, SW, 0, 0, 0);
  endtask

  initial begin
    reset = 1'b1;
    set0(0, 0, SW, 0, 0);
    set1(0, 0, SW, 0, 0, 0);
    for (int i = 0; i < 8192; i++) rmem[i] = 8'h0;
    for (int i = 0; i < 2048; i++) dm[i] = 32'h0;
    m_locked = 0; m_wait = 0; m_rv0 = 0; m_rv1 = 0; m_rd = 32'h0; m_err0 = 0; m_err1 = 0;
    e_g0 = 0; e_g1 = 0; e_we = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_store_load();
    test_fairness();
    test_lock();
    test_reset_burst();
`ifdef DM_ARB_ALIGN_CHECK_EN
    test_align();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
